// File: rtl/banked_mem_pkg.sv
// Shared types for the banked broadcast-read memory: burst encodings,
// response codes, FSM states and the WRAP length check.
package banked_mem_pkg;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01,
      BURST_WRAP  = 2'b10,
      BURST_RSVD  = 2'b11
   } burst_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      W_IDLE = 2'b00,
      W_DATA = 2'b01,
      W_RESP = 2'b10
   } w_state_e;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } r_state_e;

   // A burst is legal when its type is defined and, for WRAP, the length is 2/4/8/16 beats
   function automatic logic burst_ok(input logic [1:0] burst, input logic [7:0] len);
      logic ok;
      ok = 1'b0;
      case (burst)
         BURST_FIXED, BURST_INCR: ok = 1'b1;
         BURST_WRAP: ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/mem_bank_bw.sv
// One memory bank: byte-enabled write port, registered synchronous read port.
// Array contents have no reset; only the read register is cleared.
module mem_bank_bw #(
   parameter int DEPTH      = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      we_i,
   input  logic [$clog2(DEPTH)-1:0]  waddr_i,
   input  logic [DATA_WIDTH-1:0]     wdata_i,
   input  logic [DATA_WIDTH/8-1:0]   wstrb_i,
   input  logic                      re_i,
   input  logic [$clog2(DEPTH)-1:0]  raddr_i,
   output logic [DATA_WIDTH-1:0]     rdata_o
);

   localparam int SW = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   // Byte-lane gated write into the array
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int unsigned b = 0; b < SW; b++) begin
            if (wstrb_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
         end
      end
   end

   // Read register; sees pre-write contents when read and write hit the same row
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) rdata_q <= '0;
      else if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/banked_axi_bcast_memory.sv
// Banked memory with an AXI-style burst write port addressing single words
// and a broadcast read port returning one row from every bank at once.
module banked_axi_bcast_memory
   import banked_mem_pkg::*;
#(
   parameter int NUM_BANKS  = 32,
   parameter int BANK_DEPTH = 32,
   parameter int DATA_WIDTH = 32,
   localparam int W_ADDR_WIDTH = $clog2(NUM_BANKS*BANK_DEPTH) + 1,
   localparam int R_ADDR_WIDTH = $clog2(BANK_DEPTH),
   localparam int STRB_WIDTH   = DATA_WIDTH / 8
) (
   input  logic                            ACLK,
   input  logic                            ARESET,
   input  logic                            AWVALID,
   output logic                            AWREADY,
   input  logic [W_ADDR_WIDTH-1:0]         AWADDR,
   input  logic [1:0]                      AWBURST,
   input  logic [7:0]                      AWLEN,
   input  logic                            WVALID,
   output logic                            WREADY,
   input  logic [DATA_WIDTH-1:0]           WDATA,
   input  logic [STRB_WIDTH-1:0]           WSTRB,
   input  logic                            WLAST,
   output logic                            BVALID,
   input  logic                            BREADY,
   output logic [1:0]                      BRESP,
   input  logic                            ARVALID,
   output logic                            ARREADY,
   input  logic [R_ADDR_WIDTH-1:0]         ARADDR,
   output logic [NUM_BANKS-1:0]            RVALID,
   input  logic [NUM_BANKS-1:0]            RREADY,
   output logic [NUM_BANKS*DATA_WIDTH-1:0] RDATA,
   output logic [NUM_BANKS*2-1:0]          RRESP
);

   localparam int TOTAL_WORDS = NUM_BANKS * BANK_DEPTH;
   localparam int NB_BITS     = $clog2(NUM_BANKS);
   localparam int EXT_W       = W_ADDR_WIDTH + 9;

   // Write channel state
   w_state_e                w_state_q, w_state_d;
   logic [W_ADDR_WIDTH-1:0] base_q, base_d;
   logic [7:0]              len_q, len_d;
   logic [1:0]              burst_q, burst_d;
   logic [7:0]              cnt_q, cnt_d;
   logic                    bad_q, bad_d;     // whole burst suppressed
   logic                    err_q, err_d;     // any error seen so far
   logic [1:0]              bresp_q, bresp_d;

   // Read channel state
   r_state_e                r_state_q, r_state_d;
   logic [NUM_BANKS-1:0]    rvalid_q, rvalid_d;

   // Low until the first edge after reset so both address channels stay closed in reset
   logic                    live_q;

   logic [EXT_W-1:0]        beat_addr;
   logic                    in_range;
   logic                    w_beat;
   logic                    commit;
   logic                    last_beat;
   logic [NB_BITS-1:0]      wbank;
   logic [R_ADDR_WIDTH-1:0] wrow;
   logic                    ar_hs;

   assign AWREADY = live_q && (w_state_q == W_IDLE);
   assign WREADY  = (w_state_q == W_DATA);
   assign BVALID  = (w_state_q == W_RESP);
   assign BRESP   = bresp_q;
   assign ARREADY = live_q && (r_state_q == R_IDLE);
   assign RVALID  = rvalid_q;
   assign RRESP   = '0;

   // Address of the current beat, widened so INCR overflow past the top is detectable
   always_comb begin
      logic [EXT_W-1:0] b_ext, c_ext, l_ext;
      b_ext = EXT_W'(base_q);
      c_ext = EXT_W'(cnt_q);
      l_ext = EXT_W'(len_q);
      case (burst_q)
         BURST_INCR: beat_addr = b_ext + c_ext;
         BURST_WRAP: beat_addr = (b_ext & ~l_ext) | ((b_ext + c_ext) & l_ext);
         default:    beat_addr = b_ext;
      endcase
   end

   assign in_range  = beat_addr < EXT_W'(TOTAL_WORDS);
   assign wbank     = beat_addr[R_ADDR_WIDTH +: NB_BITS];
   assign wrow      = beat_addr[R_ADDR_WIDTH-1:0];
   assign w_beat    = WREADY && WVALID;
   assign last_beat = (cnt_q == len_q);
   assign commit    = w_beat && !bad_q && in_range;
   assign ar_hs     = ARREADY && ARVALID;

   // Write FSM registers
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         w_state_q <= W_IDLE;
         base_q    <= '0;
         len_q     <= '0;
         burst_q   <= '0;
         cnt_q     <= '0;
         bad_q     <= 1'b0;
         err_q     <= 1'b0;
         bresp_q   <= RESP_OKAY;
         live_q    <= 1'b0;
      end else begin
         w_state_q <= w_state_d;
         base_q    <= base_d;
         len_q     <= len_d;
         burst_q   <= burst_d;
         cnt_q     <= cnt_d;
         bad_q     <= bad_d;
         err_q     <= err_d;
         bresp_q   <= bresp_d;
         live_q    <= 1'b1;
      end
   end

   // Write FSM next state: burst ends on beat count, errors accumulate into BRESP
   always_comb begin
      logic beat_err;
      w_state_d = w_state_q;
      base_d    = base_q;
      len_d     = len_q;
      burst_d   = burst_q;
      cnt_d     = cnt_q;
      bad_d     = bad_q;
      err_d     = err_q;
      bresp_d   = bresp_q;
      beat_err  = 1'b0;
      case (w_state_q)
         W_IDLE: begin
            if (AWREADY && AWVALID) begin
               base_d    = AWADDR;
               len_d     = AWLEN;
               burst_d   = AWBURST;
               cnt_d     = '0;
               bad_d     = !burst_ok(AWBURST, AWLEN);
               err_d     = !burst_ok(AWBURST, AWLEN);
               w_state_d = W_DATA;
            end
         end
         W_DATA: begin
            if (WVALID) begin
               beat_err = !in_range || (WLAST != last_beat);
               err_d    = err_q || beat_err;
               cnt_d    = cnt_q + 8'd1;
               if (last_beat) begin
                  bresp_d   = (err_q || beat_err) ? RESP_SLVERR : RESP_OKAY;
                  w_state_d = W_RESP;
               end
            end
         end
         W_RESP: begin
            if (BREADY) begin
               bresp_d   = RESP_OKAY;
               w_state_d = W_IDLE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   // Read FSM registers
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_state_q <= R_IDLE;
         rvalid_q  <= '0;
      end else begin
         r_state_q <= r_state_d;
         rvalid_q  <= rvalid_d;
      end
   end

   // Read FSM next state: each bank's valid drops on its own handshake
   always_comb begin
      r_state_d = r_state_q;
      rvalid_d  = rvalid_q;
      case (r_state_q)
         R_IDLE: begin
            if (ar_hs) begin
               rvalid_d  = '1;
               r_state_d = R_DATA;
            end
         end
         R_DATA: begin
            rvalid_d = rvalid_q & ~RREADY;
            if (rvalid_d == '0) r_state_d = R_IDLE;
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
      mem_bank_bw #(
         .DEPTH      (BANK_DEPTH),
         .DATA_WIDTH (DATA_WIDTH)
      ) u_bank (
         .clk_i   (ACLK),
         .rst_i   (ARESET),
         .we_i    (commit && (wbank == NB_BITS'(g))),
         .waddr_i (wrow),
         .wdata_i (WDATA),
         .wstrb_i (WSTRB),
         .re_i    (ar_hs),
         .raddr_i (ARADDR),
         .rdata_o (RDATA[g*DATA_WIDTH +: DATA_WIDTH])
      );
   end

endmodule
